// File: rtl/mult_pkg.sv
// Shared constants for the iterative multiplier.
//   ST_*       : FSM state encoding (IDLE / BUSY / DONE)
//   cnt_width  : bits needed to hold an iteration count of 0..w
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (a, b, is_signed)
//   a, b                : WIDTH-bit operands
//   is_signed           : 1 = two's complement operands, 0 = unsigned
//   out_valid/out_ready : result handshake
//   p                   : 2*WIDTH-bit product, held until the next result
//   busy                : high while iterating
// Signed operands are reduced to magnitudes up front; the sign is reapplied
// once at the end, so the iteration loop is purely unsigned.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam int AW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               ovld_q, ovld_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     upper_sum;
  logic [AW-1:0]      acc_step;
  logic [2*WIDTH-1:0] prod, prod_sgn;

  // Magnitude of the most-negative value (2^(WIDTH-1)) still fits WIDTH bits.
  assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Add into the upper WIDTH+1 bits, then shift the whole accumulator right.
  assign upper_sum = acc_q[AW-1:WIDTH] + (mplr_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_step  = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
  assign prod      = acc_step[2*WIDTH-1:0];
  assign prod_sgn  = neg_q ? (~prod + 1'b1) : prod;

  assign in_ready  = (state_q == ST_IDLE) && rst_n;
  assign busy      = (state_q == ST_BUSY);
  assign out_valid = ovld_q;
  assign p         = p_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    ovld_d  = ovld_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d = a_mag;
          mplr_d  = b_mag;
          neg_d   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d  = acc_step;
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          p_d     = prod_sgn;
          ovld_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ovld_q  <= ovld_d;
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Randomized self-checking bench for seq_mult (WIDTH=4 and WIDTH=8 instances).
module tb_seq_mult;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv4, ir4, s4, ov4, or4, bz4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic       iv8, ir8, s8, ov8, or8, bz8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(bz4)
  );

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(bz8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as integers and multiply, keep 2w bits.
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] ta,
                                          input logic [7:0] tb, input bit ts);
    longint one = 1;
    longint sa, sb, pr;
    sa = longint'(ta) & ((one << w) - 1);
    sb = longint'(tb) & ((one << w) - 1);
    if (ts && sa >= (one << (w - 1))) sa = sa - (one << w);
    if (ts && sb >= (one << (w - 1))) sb = sb - (one << w);
    pr = sa * sb;
    return 16'(pr & ((one << (2 * w)) - 1));
  endfunction

  task automatic set_in(input bit w8, input bit v, input logic [7:0] ta,
                        input logic [7:0] tb, input bit ts);
    if (w8) begin iv8 = v; a8 = ta; b8 = tb; s8 = ts; end
    else begin iv4 = v; a4 = ta[3:0]; b4 = tb[3:0]; s4 = ts; end
  endtask

  task automatic set_or(input bit w8, input bit v);
    if (w8) or8 = v; else or4 = v;
  endtask

  function automatic bit o_ir(input bit w8); return w8 ? ir8 : ir4; endfunction
  function automatic bit o_ov(input bit w8); return w8 ? ov8 : ov4; endfunction
  function automatic bit o_bz(input bit w8); return w8 ? bz8 : bz4; endfunction
  function automatic logic [15:0] o_p(input bit w8); return w8 ? p8 : {8'h00, p4}; endfunction

  task automatic junk(input bit w8);
    set_in(w8, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  // One transaction from IDLE; in_valid stays high with junk operands while
  // busy/done, and out_ready is withheld for 'hold' cycles in DONE.
  task automatic txn(input bit w8, input logic [7:0] ta, input logic [7:0] tb,
                     input bit ts, input int hold, input string tag);
    int w;
    int lat;
    int bcnt;
    logic [15:0] exp, held;
    w = w8 ? 8 : 4;
    exp = ref_mul(w, ta, tb, ts);
    @(negedge clk);
    chk({tag, "/in_ready"}, 64'(o_ir(w8)), 64'(1));
    set_in(w8, 1'b1, ta, tb, ts);
    set_or(w8, 1'b0);
    @(negedge clk);
    junk(w8);
    lat = 0;
    bcnt = 0;
    while (!o_ov(w8) && lat < 40) begin
      bcnt += int'(o_bz(w8));
      lat++;
      @(negedge clk);
      junk(w8);
    end
    chk({tag, "/latency"}, 64'(lat), 64'(w));
    chk({tag, "/busy_cycles"}, 64'(bcnt), 64'(w));
    chk({tag, "/p"}, 64'(o_p(w8)), 64'(exp));
    held = o_p(w8);
    repeat (hold) begin
      @(negedge clk);
      junk(w8);
      chk({tag, "/hold_p"}, 64'(o_p(w8)), 64'(held));
      chk({tag, "/hold_ov_rdy"}, {62'd0, o_ov(w8), o_ir(w8)}, 64'b10);
    end
    set_in(w8, 1'b0, 8'h00, 8'h00, 1'b0);
    set_or(w8, 1'b1);
    @(negedge clk);
    set_or(w8, 1'b0);
    chk({tag, "/release"}, {62'd0, o_ov(w8), o_ir(w8)}, 64'b01);
    chk({tag, "/p_kept"}, 64'(o_p(w8)), 64'(held));
  endtask

  initial begin
    logic [7:0] q[$];
    int acc_n, got_n, cyc, viol, stale;
    logic [7:0] ra, rb;
    bit rs, rv;

    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_in(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    or4 = 1'b0;
    or8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset/ir_ov_bz", {61'd0, ir4, ov4, bz4}, 64'd0);
    chk("reset/p4", 64'(p4), 64'd0);
    chk("reset/p8", 64'(p8), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset/ir_after", 64'(ir4), 64'd1);

    // Directed WIDTH=4
    txn(1'b0, 8'h08, 8'h02, 1'b0, 0, "u8x2");
    txn(1'b0, 8'h0f, 8'h0f, 1'b0, 0, "u15x15");
    txn(1'b0, 8'h08, 8'h08, 1'b1, 0, "sm8xm8");
    txn(1'b0, 8'h08, 8'h07, 1'b1, 0, "sm8x7");
    txn(1'b0, 8'h0d, 8'h06, 1'b1, 5, "hold5");
    txn(1'b0, 8'h00, 8'h09, 1'b1, 0, "szero");

    // Reset during the second BUSY cycle
    txn(1'b0, 8'h07, 8'h07, 1'b0, 0, "pre_rst");
    @(negedge clk);
    set_in(1'b0, 1'b1, 8'h05, 8'h03, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("rst_mid/busy_before", 64'(bz4), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid/p", 64'(p4), 64'd0);
    chk("rst_mid/ir_ov_bz", {61'd0, ir4, ov4, bz4}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid/ir_after", 64'(ir4), 64'd1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      stale += int'(ov4) + int'(bz4);
    end
    chk("rst_mid/no_stale", 64'(stale), 64'd0);

    // Directed WIDTH=8
    txn(1'b1, 8'hff, 8'hff, 1'b0, 0, "w8_u255");
    txn(1'b1, 8'h80, 8'h80, 1'b1, 0, "w8_sm128sq");
    txn(1'b1, 8'h80, 8'h7f, 1'b1, 2, "w8_sm128x127");

    // Random WIDTH=4 with handshake gaps
    acc_n = 0; got_n = 0; cyc = 0; viol = 0;
    while ((acc_n < 200 || q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (ir4 && (bz4 || ov4)) viol++;
      rv = (acc_n < 200) && ($urandom_range(0, 2) != 0);
      ra = 8'($urandom_range(0, 15));
      rb = 8'($urandom_range(0, 15));
      rs = 1'($urandom);
      set_in(1'b0, rv, ra, rb, rs);
      if (rv && ir4) begin
        q.push_back(8'(ref_mul(4, ra, rb, rs)));
        acc_n++;
      end
      or4 = ($urandom_range(0, 2) == 0);
      if (or4 && ov4) begin
        got_n++;
        if (q.size() == 0) chk("rand/extra_product", 64'(p4), 64'hdead);
        else chk("rand/p", 64'(p4), 64'(q.pop_front()));
      end
    end
    or4 = 1'b0;
    set_in(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("rand/timeout", 64'(cyc < 20000), 64'd1);
    chk("rand/count", 64'(got_n), 64'd200);
    chk("rand/ready_outside_idle", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised iterative shift-add multiplier; successor to the fixed 4x4 combinational array multiplier.
- Accepts one WIDTH x WIDTH operand pair via a valid/ready handshake and computes one partial product per clock.
- Supports unsigned or two's-complement signed operands, selected per transaction.
- Presents a 2*WIDTH-bit product via valid/ready. Used where area matters more than throughput.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- in_valid  in  1  operand pair and mode are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1 = treat a, b as two's complement; 0 = unsigned.
- out_valid  out  1  p holds a completed product.
- out_ready  in  1  consumer accepts p.
- p  out  2*WIDTH  product.
- busy  out  1  high while iterating (BUSY state).

Interface: one clock; reset is synchronous and active-low (clk, rst_n).

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset:
  - rst_n low at a clk edge forces state=IDLE, p=0, out_valid=0, busy=0, and clears all internal registers.
  - in_ready = (state==IDLE) && rst_n, so it is 0 while reset is asserted.
  - Reset mid-BUSY or mid-DONE aborts the operation; no result is produced.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid && in_ready (edge E0), latch the mode and form the operands:
    - is_signed=1: store |a| and |b| as WIDTH-bit unsigned magnitudes, and store neg = a[MSB]^b[MSB].
    - is_signed=0: store a and b unchanged, and store neg=0.
  - Clear the accumulator, load iteration count = WIDTH, go to BUSY.
  - The magnitude of the most-negative value (e.g. -8 for WIDTH=4) is 2^(WIDTH-1) and fits unsigned WIDTH bits.
- BUSY:
  - busy=1, in_ready=0.
  - Each edge E1..E_WIDTH:
    - If the multiplier LSB is 1, add the multiplicand to the upper WIDTH+1 bits of the 2*WIDTH+1-bit accumulator.
    - Shift the accumulator and multiplier right by 1.
    - Decrement the count.
  - At edge E_WIDTH: p <= neg ? -acc : acc (2*WIDTH bits), out_valid <= 1, state <= DONE.
  - Latency: out_valid is first high in the cycle after E_WIDTH, i.e. WIDTH clocks after the accept edge, regardless of operand values (no early termination).
  - in_valid and operand changes during BUSY are ignored.
- DONE:
  - out_valid=1; p is stable and unchanged until the handshake.
  - On an edge with out_ready=1: out_valid <= 0, state <= IDLE; p keeps its value.
  - out_ready low holds DONE indefinitely; in_ready stays 0 (no overlap or back-to-back accept).
- Throughput: one product per WIDTH+2 clocks minimum.
- Width rules:
  - Unsigned result range is 0..(2^WIDTH-1)^2.
  - Signed result range is -(2^(W-1))(2^(W-1)-1)..2^(2W-2). Both fit in 2*WIDTH bits, so there is no overflow flag.
  - A zero result with neg=1 yields 0; negating zero is harmless.
- out_ready asserted outside DONE has no effect.

Decomposition:
- Shared package mult_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2;
  - a function for the counter width clog2(WIDTH+1).
- No sub-module. The FSM and shift-add datapath stay in seq_mult; the abs/negate logic is inline.

Test Plan:
1. WIDTH=4, unsigned, a=4'b1000, b=4'b0010 -> p=8'h10; out_valid rises exactly 4 clocks after the accept edge; busy high for 4 cycles.
2. WIDTH=4, unsigned, a=15, b=15 -> p=8'hE1. Then signed a=-8, b=-8 -> p=8'h40; signed a=-8, b=7 -> p=8'hC8 (-56).
3. WIDTH=4, out_ready held low 5 cycles in DONE with in_valid=1 and new operands -> p stable, out_valid=1, in_ready=0. Release out_ready -> IDLE next edge, then new operands accepted.
4. WIDTH=4, rst_n pulled low at the second BUSY cycle -> next edge p=0, out_valid=0, busy=0, state IDLE. in_ready=0 during reset and 1 after release; no stale result appears.
5. WIDTH=8: unsigned 255*255 -> p=16'hFE01; signed -128*-128 -> p=16'h4000; signed -128*127 -> p=16'hC080; latency 8 clocks each.
6. WIDTH=4, random 200 transactions, mixed is_signed, random in_valid/out_ready gaps -> every p matches the reference model; a product is never duplicated or dropped; in_ready is never high outside IDLE.
